// File: rtl/pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module : pe_array_seq
// Brief  : Job sequencer for an N_ROWS x N_COLS systolic PE array: weight load,
//          vector streaming, drain, and result-buffer write generation.
// Rev    : 1.0
// ============================================================================
module pe_array_seq #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8,
  parameter int LEN_W  = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      reuse_w,
  input  logic [LEN_W-1:0]          num_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [$clog2(N_ROWS)-1:0] w_rd_addr,
  output logic                      wwrite,
  output logic                      d_rd_en,
  output logic [LEN_W-1:0]          d_rd_addr,
  output logic                      active,
  output logic                      out_wr_en,
  output logic [LEN_W-1:0]          out_wr_addr
);

  localparam int AW       = $clog2(N_ROWS);
  localparam int PIPE_LAT = N_ROWS + N_COLS;
  localparam int CNT_W    = (LEN_W > $clog2(N_ROWS + 1)) ? LEN_W : $clog2(N_ROWS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLOAD  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_num_vec;
  logic [LEN_W-1:0]    r_out_addr;
  logic [PIPE_LAT-1:0] r_dly;
  logic                r_wwrite;
  logic                r_active;
  logic                w_wload_end;
  logic                w_stream_end;
  logic                w_last_wr;

  assign w_wload_end  = (r_cnt == CNT_W'(N_ROWS));
  assign w_stream_end = (r_cnt == CNT_W'(r_num_vec - LEN_W'(1)));
  assign w_last_wr    = r_dly[PIPE_LAT-1] && (r_out_addr == r_num_vec - LEN_W'(1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!reuse_w)           w_next = S_WLOAD;
          else if (num_vec != '0) w_next = S_STREAM;
          else                    w_next = S_DONE;
        end
      end
      S_WLOAD:  if (w_wload_end) w_next = (r_num_vec != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (w_stream_end) w_next = S_DRAIN;
      S_DRAIN:  if (w_last_wr) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    w_rd_en   = (r_state == S_WLOAD) && (r_cnt < CNT_W'(N_ROWS));
    w_rd_addr = w_rd_en ? r_cnt[AW-1:0] : '0;
    d_rd_en   = (r_state == S_STREAM);
    d_rd_addr = d_rd_en ? r_cnt[LEN_W-1:0] : '0;
  end

  // Counter restarts on every state change so it doubles as the per-phase address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_num_vec  <= '0;
      r_out_addr <= '0;
      r_dly      <= '0;
      r_wwrite   <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) r_num_vec <= num_vec;
      if (((r_state == S_WLOAD) || (r_state == S_STREAM)) && (w_next == r_state))
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
      r_wwrite <= w_rd_en;
      r_active <= d_rd_en;
      r_dly    <= {r_dly[PIPE_LAT-2:0], d_rd_en};
      if (r_state == S_DONE)   r_out_addr <= '0;
      else if (r_dly[PIPE_LAT-1]) r_out_addr <= r_out_addr + LEN_W'(1);
    end
  end

  assign wwrite      = r_wwrite;
  assign active      = r_active;
  assign out_wr_en   = r_dly[PIPE_LAT-1];
  assign out_wr_addr = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_array_seq
// Brief  : Scoreboard bench for pe_array_seq; expected strobe events come from
//          a cycle-formula job model, a monitor pops and compares them.
// Rev    : 1.0
// ============================================================================
module tb_pe_array_seq;

  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 4;
  localparam int LEN_W    = 10;
  localparam int PIPE_LAT = N_ROWS + N_COLS;
  localparam int AW       = $clog2(N_ROWS);

  logic             clock;
  logic             reset;
  logic             start;
  logic             reuse_w;
  logic [LEN_W-1:0] num_vec;
  logic             busy, done, w_rd_en, wwrite, d_rd_en, active, out_wr_en;
  logic [AW-1:0]    w_rd_addr;
  logic [LEN_W-1:0] d_rd_addr, out_wr_addr;

  pe_array_seq #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .reuse_w(reuse_w), .num_vec(num_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .wwrite(wwrite),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .active(active), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Period p is the clock period that ends at rising edge number p.
  int ne = 0;
  always @(posedge clock) ne <= ne + 1;

  typedef struct {int cyc; int addr;} ev_t;
  ev_t   evq[6][$];
  string ch_name[6] = '{"w_rd_en", "wwrite", "d_rd_en", "active", "out_wr_en", "done"};

  int job_start = 0;
  int job_done  = -1;
  int cur_p     = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  task automatic chk(input bit ok, input string nm, input int p, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s period=%0d actual=%0d expected=%0d", nm, p, act, exp);
  endtask

  task automatic push_ev(input int c, input int cyc, input int addr);
    ev_t e;
    e.cyc  = cyc;
    e.addr = addr;
    evq[c].push_back(e);
  endtask

  // Job model: every strobe's cycle follows from the phase lengths and latencies.
  task automatic model_job(input int s, input bit ru, input int n);
    int wl;
    wl = ru ? 0 : N_ROWS + 1;
    if (!ru) begin
      for (int i = 0; i < N_ROWS; i++) begin
        push_ev(0, s + 1 + i, i);
        push_ev(1, s + 2 + i, -1);
      end
    end
    for (int i = 0; i < n; i++) begin
      push_ev(2, s + 1 + wl + i, i);
      push_ev(3, s + 2 + wl + i, -1);
      push_ev(4, s + 1 + wl + i + PIPE_LAT, i);
    end
    job_start = s;
    job_done  = s + wl + n + ((n != 0) ? PIPE_LAT : 0) + 1;
    push_ev(5, job_done, -1);
  endtask

  task automatic model_reset(input int r);
    if (job_done > r) job_done = r;
    for (int c = 0; c < 6; c++)
      while (evq[c].size() > 0 && evq[c][evq[c].size()-1].cyc > r) void'(evq[c].pop_back());
  endtask

  task automatic drive(input bit st, input bit ru, input int n, input bit rs);
    @(negedge clock);
    start   = st;
    reuse_w = ru;
    num_vec = n[LEN_W-1:0];
    reset   = rs;
    cur_p   = ne + 1;
    if (rs) model_reset(cur_p);
    else if (st && cur_p > job_done) model_job(cur_p, ru, n);
  endtask

  task automatic idle_until_free();
    while (cur_p + 1 <= job_done) drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: one sample per period, just after the edge that opens it.
  int   mp;
  logic stb[6];
  int   adr[6];
  always begin
    @(posedge clock);
    #1;
    mp = ne + 1;
    stb[0] = w_rd_en;   adr[0] = int'(w_rd_addr);
    stb[1] = wwrite;    adr[1] = -1;
    stb[2] = d_rd_en;   adr[2] = int'(d_rd_addr);
    stb[3] = active;    adr[3] = -1;
    stb[4] = out_wr_en; adr[4] = int'(out_wr_addr);
    stb[5] = done;      adr[5] = -1;
    if (reset)
      chk({busy, done, w_rd_en, w_rd_addr, wwrite, d_rd_en, d_rd_addr, active, out_wr_en,
           out_wr_addr} == '0, "reset_zero", mp,
          int'({busy, done, w_rd_en, wwrite, d_rd_en, active, out_wr_en}), 0);
    chk(busy == ((mp > job_start) && (mp <= job_done)), "busy", mp, int'(busy),
        int'((mp > job_start) && (mp <= job_done)));
    chk(!(wwrite && active), "wwrite_active_overlap", mp, int'(wwrite && active), 0);
    for (int c = 0; c < 6; c++) begin
      bit   hit;
      ev_t  e;
      hit = (evq[c].size() > 0) && (evq[c][0].cyc == mp);
      chk(stb[c] == hit, ch_name[c], mp, int'(stb[c]), int'(hit));
      if (hit) begin
        e = evq[c].pop_front();
        if (stb[c] && e.addr >= 0)
          chk(adr[c] == e.addr, {ch_name[c], "_addr"}, mp, adr[c], e.addr);
      end
    end
  end

  initial begin
    int left;
    start = 1'b0; reuse_w = 1'b0; num_vec = '0; reset = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);

    drive(1'b1, 1'b0, 3, 1'b0); idle_until_free();        // weight load + 3 vectors
    drive(1'b1, 1'b1, 3, 1'b0); idle_until_free();        // reuse weights
    drive(1'b1, 1'b0, 0, 1'b0); idle_until_free();        // load only
    drive(1'b1, 1'b1, 0, 1'b0); idle_until_free();        // empty job

    drive(1'b1, 1'b0, 3, 1'b0);                           // start pulses while busy
    repeat (2) drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 7, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 5, 1'b0);
    idle_until_free();
    repeat (30) drive(1'b1, 1'b1, 2, 1'b0);               // start held: back-to-back jobs
    idle_until_free();

    drive(1'b1, 1'b0, 3, 1'b0);                           // reset mid-stream
    repeat (6) drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1);
    repeat (20) drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 3, 1'b0); idle_until_free();

    drive(1'b1, 1'b0, 3, 1'b1);                           // reset beats start
    repeat (5) drive(1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      left = int'($urandom % 100);
      if (left < 2) drive(1'b0, 1'b0, 0, 1'b1);
      else drive(left < 15, 1'($urandom % 2), int'($urandom_range(0, 24)), 1'b0);
    end
    idle_until_free();

    drive(1'b1, 1'b1, 1023, 1'b0); idle_until_free();     // full-range vector count
    drive(1'b1, 1'b0, 1023, 1'b0); idle_until_free();
    repeat (5) drive(1'b0, 1'b0, 0, 1'b0);

    left = 0;
    for (int c = 0; c < 6; c++) left += evq[c].size();
    chk(left == 0, "pending_events", cur_p, left, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
